// File: rtl/shared_adder_arb.sv
// shared_adder_arb
//   Round-robin arbiter in front of one shared WIDTH-bit adder with a single
//   result register (one-entry output buffer, full throughput when draining).
//
//   Parameters
//     WIDTH : operand / result width (default 64)
//     NREQ  : number of requesters, 2..4 (default 3)
//
//   Ports
//     clk        : clock, rising edge
//     reset      : asynchronous, active-high reset
//     req_valid  : [NREQ]        requester i presents operands
//     req_a      : [NREQ*WIDTH]  operand A, requester i in [i*WIDTH +: WIDTH]
//     req_b      : [NREQ*WIDTH]  operand B, packed like req_a
//     req_sub    : [NREQ]        (only with SHARED_ADDER_SUB_EN) subtract a - b
//     req_ready  : [NREQ]        one-hot grant, zero when no grant
//     res_valid  : result register holds an unconsumed result
//     res_data   : [WIDTH]       registered sum (carry-out discarded)
//     res_id     : [2]           requester that owns res_data
//     res_ready  : consumer accepts the result
//
//   Optional feature: define SHARED_ADDER_SUB_EN to add req_sub and allow
//   subtraction computed as a + ~b + 1.
module shared_adder_arb #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef SHARED_ADDER_SUB_EN
    input  logic [NREQ-1:0]       req_sub,
`else
    // no req_sub port: every operation is an addition
`endif
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    output logic [WIDTH-1:0]      res_data,
    output logic [1:0]            res_id,
    input  logic                  res_ready
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_r;
    logic [1:0]       ptr_r;
    logic [1:0]       res_id_r;
    logic [WIDTH-1:0] res_data_r;

    logic             grant_any_s;
    logic [1:0]       grant_idx_s;
    logic [2:0]       cand_s;
    logic             accept_s;
    logic [NREQ-1:0]  ready_s;
    logic             req_xfer_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH-1:0] sum_s;
    logic [1:0]       ptr_next_s;
`ifdef SHARED_ADDER_SUB_EN
    logic             sub_s;
`endif

    // Round-robin search: first asserted req_valid at or after ptr, cyclically.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = 2'd0;
        cand_s      = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, ptr_r} + 3'(k);
            if (cand_s >= 3'(NREQ)) begin
                cand_s = cand_s - 3'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_any_s && req_valid[cand_s[1:0]]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand_s[1:0];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Grant is only issued when the result slot is free or being drained this
    // edge; reset forces it low immediately since it is combinational.
    always_comb begin
        ready_s = {NREQ{1'b0}};
        if (state_r == EMPTY) begin
            accept_s = 1'b1;
        end else begin
            accept_s = res_ready;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_any_s && accept_s && !reset && (grant_idx_s == 2'(i))) begin
                ready_s[i] = 1'b1;
            end else begin
                ready_s[i] = 1'b0;
            end
        end
        req_xfer_s = |ready_s;
    end

    // Operand select and the shared adder.
    always_comb begin
        op_a_s = {WIDTH{1'b0}};
        op_b_s = {WIDTH{1'b0}};
`ifdef SHARED_ADDER_SUB_EN
        sub_s  = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == 2'(i)) begin
                op_a_s = req_a[i*WIDTH +: WIDTH];
                op_b_s = req_b[i*WIDTH +: WIDTH];
`ifdef SHARED_ADDER_SUB_EN
                sub_s  = req_sub[i];
`endif
            end else begin
                op_a_s = op_a_s;
            end
        end
`ifdef SHARED_ADDER_SUB_EN
        if (sub_s) begin
            sum_s = op_a_s + ~op_b_s + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            sum_s = op_a_s + op_b_s;
        end
`else
        sum_s = op_a_s + op_b_s;
`endif
        if (grant_idx_s == 2'(NREQ-1)) begin
            ptr_next_s = 2'd0;
        end else begin
            ptr_next_s = grant_idx_s + 2'd1;
        end
    end

    // Result-register FSM: load on request transfer, empty on a bare drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= EMPTY;
            ptr_r      <= 2'd0;
            res_id_r   <= 2'd0;
            res_data_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (req_xfer_s) begin
                        state_r    <= FULL;
                        res_data_r <= sum_s;
                        res_id_r   <= grant_idx_s;
                        ptr_r      <= ptr_next_s;
                    end else begin
                        state_r    <= EMPTY;
                    end
                end
                FULL: begin
                    if (req_xfer_s) begin
                        state_r    <= FULL;
                        res_data_r <= sum_s;
                        res_id_r   <= grant_idx_s;
                        ptr_r      <= ptr_next_s;
                    end else if (res_ready) begin
                        state_r    <= EMPTY;
                    end else begin
                        state_r    <= FULL;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign res_valid = (state_r == FULL);
    assign res_data  = res_data_r;
    assign res_id    = res_id_r;

endmodule

// File: tb/tb_shared_adder_arb.sv
module tb_shared_adder_arb;

    localparam int W = 64;
    localparam int N = 3;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_sub;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic [W-1:0]   res_data;
    logic [1:0]     res_id;
    logic           res_ready;

    int checks;
    int errors;

    // reference model: one result slot plus a rotating priority pointer
    bit         m_full;
    logic [W-1:0] m_data;
    int         m_id;
    int         m_ptr;

    shared_adder_arb #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef SHARED_ADDER_SUB_EN
        .req_sub   (req_sub),
`endif
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_id   = 0;
        m_ptr  = 0;
    endtask

    // one clock cycle: drive, check grant, clock, update model, check result
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a,
                        input logic [N*W-1:0] b, input logic [N-1:0] sub,
                        input logic rr);
        int g;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] opa;
        logic [W-1:0] opb;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        res_ready = rr;
        #1;
        g = model_grant(v, m_ptr);
        exp_rdy = '0;
        if (g >= 0 && (!m_full || rr)) exp_rdy[g] = 1'b1;
        check_eq("req_ready", W'(req_ready), W'(exp_rdy));
        @(posedge clk);
        if (exp_rdy != '0) begin
            opa = a[g*W +: W];
            opb = b[g*W +: W];
`ifdef SHARED_ADDER_SUB_EN
            if (sub[g]) m_data = opa - opb;
            else        m_data = opa + opb;
`else
            m_data = opa + opb;
`endif
            m_full = 1'b1;
            m_id   = g;
            m_ptr  = (g + 1) % N;
        end else if (m_full && rr) begin
            m_full = 1'b0;
        end
        #1;
        check_eq("res_valid", W'(res_valid), W'(m_full));
        if (m_full) begin
            check_eq("res_data", res_data, m_data);
            check_eq("res_id", W'(res_id), W'(m_id));
        end
    endtask

    initial begin
        logic [N*W-1:0] ra;
        logic [N*W-1:0] rb;
        logic [W-1:0]   held;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        res_ready = 1'b0;
        model_reset();
        #1;
        check_eq("rst_res_valid", W'(res_valid), '0);
        check_eq("rst_res_data", res_data, '0);
        check_eq("rst_res_id", W'(res_id), '0);
        check_eq("rst_req_ready", W'(req_ready), '0);
        #16;
        reset = 1'b0;

        // single add from requester 0
        step(3'b001, {128'd0, 64'h7}, {128'd0, 64'h9}, 3'b000, 1'b1);
        check_eq("add_data", res_data, 64'h10);
        check_eq("add_id", W'(res_id), 64'd0);

        // wrap-around from requester 1, carry dropped
        step(3'b010, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0},
             {64'd0, 64'h2, 64'd0}, 3'b000, 1'b1);
        check_eq("wrap_data", res_data, 64'h1);

        // backpressure: three stalled cycles, then drain-and-refill
        held = res_data;
        for (int i = 0; i < 3; i++) begin
            step(3'b010, {64'd0, 64'h11, 64'd0}, {64'd0, 64'h22, 64'd0}, 3'b000, 1'b0);
            check_eq("bp_stable", res_data, held);
        end
        step(3'b010, {64'd0, 64'h11, 64'd0}, {64'd0, 64'h22, 64'd0}, 3'b000, 1'b1);
        check_eq("bp_refill_id", W'(res_id), 64'd1);
        check_eq("bp_refill_data", res_data, 64'h33);

        // load 5, then reset asynchronously while full
        step(3'b001, {128'd0, 64'h2}, {128'd0, 64'h3}, 3'b000, 1'b1);
        check_eq("pre_rst_data", res_data, 64'h5);
        req_valid = 3'b111;
        res_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_res_valid", W'(res_valid), '0);
        check_eq("midrst_res_data", res_data, '0);
        check_eq("midrst_req_ready", W'(req_ready), '0);
        #2;
        reset = 1'b0;
        model_reset();

        // round-robin from pointer 0 after reset
        for (int i = 0; i < 4; i++) begin
            step(3'b111, {64'd30, 64'd20, 64'd10}, {64'd3, 64'd2, 64'd1}, 3'b000, 1'b1);
            check_eq("rr_id", W'(res_id), W'(i % N));
        end

`ifdef SHARED_ADDER_SUB_EN
        step(3'b001, {128'd0, 64'h3}, {128'd0, 64'h5}, 3'b001, 1'b1);
        check_eq("sub_data", res_data, 64'hFFFF_FFFF_FFFF_FFFE);
`endif

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N*2; i++) begin
                ra[i*32 +: 32] = $urandom;
                rb[i*32 +: 32] = $urandom;
            end
            if (($urandom % 8) == 0) begin
                for (int i = 0; i < N; i++) ra[i*W +: W] = '1;
            end
            step(N'($urandom), ra, rb, N'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
